tl_ram_slave: RTL

TileLink-UL slave endpoint that sits directly downstream of the crossbar. It accepts single-beat Get and PutFullData requests on the A channel and services them from an internal 64-bit-wide, byte-maskable RAM. It returns AccessAckData or AccessAck on the D channel after a fixed, configurable latency. It is the memory target addressed by the crossbar masters in the 0x8000_0000 region.

---
 rtl/tl_pkg.sv | 40 ++++
 rtl/tl_ram_array.sv | 32 +++
 rtl/tl_ram_slave.sv | 132 +++++++++++++
 3 files changed

// File: rtl/tl_pkg.sv
// Shared TileLink-UL definitions: opcodes, slave FSM states, captured request.
package tl_pkg;

  // A-channel request opcodes
  localparam logic [2:0] TL_GET             = 3'd4;
  localparam logic [2:0] TL_PUT_F           = 3'd0;
  // D-channel response opcodes
  localparam logic [2:0] TL_ACCESS_ACK      = 3'd0;
  localparam logic [2:0] TL_ACCESS_ACK_DATA = 3'd1;

  // Single-outstanding slave FSM
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } tl_state_e;

  // Everything the D channel needs, captured on the accept edge
  typedef struct packed {
    logic [2:0] opcode;    // response opcode already resolved
    logic [2:0] size;
    logic [3:0] source;
    logic       denied;
    logic       has_data;  // d_data comes from the RAM read port
  } tl_req_t;

  // Natural alignment for sizes up to 8 bytes; larger sizes never align here
  function automatic logic is_aligned(input logic [2:0] addr_lo, input logic [2:0] size);
    logic ok;
    case (size)
      3'd0:    ok = 1'b1;
      3'd1:    ok = (addr_lo[0] == 1'b0);
      3'd2:    ok = (addr_lo[1:0] == 2'b00);
      3'd3:    ok = (addr_lo == 3'b000);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/tl_ram_array.sv
// 64-bit x DEPTH RAM with per-byte write enables and a registered read port.
module tl_ram_array #(
  parameter int DEPTH = 512,
  parameter int AW    = 9
) (
  input  logic          clk,
  input  logic          rd_en,
  input  logic [7:0]    wr_be,
  input  logic [AW-1:0] addr,
  input  logic [63:0]   wdata,
  output logic [63:0]   rdata
);

  logic [63:0] mem [DEPTH];

  // Byte-lane writes; contents are deliberately not reset
  always_ff @(posedge clk) begin
    for (int i = 0; i < 8; i++) begin
      if (wr_be[i]) begin
        mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Registered read; holds its value until the next read so the response stays stable
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/tl_ram_slave.sv
// TileLink-UL single-beat RAM slave: Get/PutFullData with fixed response latency.
module tl_ram_slave
  import tl_pkg::*;
#(
  parameter logic [63:0] BASE    = 64'h8000_0000,
  parameter int          DEPTH   = 512,
  parameter int          LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  // A channel
  input  logic        a_valid,
  output logic        a_ready,
  input  logic [2:0]  a_opcode,
  input  logic [2:0]  a_size,
  input  logic [3:0]  a_source,
  input  logic [63:0] a_address,
  input  logic [7:0]  a_mask,
  input  logic [63:0] a_data,
  // D channel
  output logic        d_valid,
  input  logic        d_ready,
  output logic [2:0]  d_opcode,
  output logic [2:0]  d_size,
  output logic [3:0]  d_source,
  output logic [63:0] d_data,
  output logic        d_denied
);

  localparam int          AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [63:0] LIMIT    = BASE + 64'(DEPTH) * 64'd8;
  localparam logic [3:0]  CNT_LOAD = 4'(LATENCY - 1);

  tl_state_e     state_reg, state_next;
  logic [3:0]    cnt_reg, cnt_next;
  tl_req_t       req_reg;
  logic          accept;
  logic          in_range, is_get, is_put, denied;
  logic [AW-1:0] word_idx;
  logic [7:0]    ram_we;
  logic          ram_re;
  logic [63:0]   ram_rdata;

  // Request decode: range, size, alignment and opcode legality
  always_comb begin
    in_range = (a_address >= BASE) && (a_address < LIMIT);
    is_get   = (a_opcode == TL_GET);
    is_put   = (a_opcode == TL_PUT_F);
    denied   = !in_range || (a_size > 3'd3) || !is_aligned(a_address[2:0], a_size)
               || !(is_get || is_put);
    word_idx = AW'((a_address - BASE) >> 3);
  end

  // RAM is touched only on the accept edge and only for a legal request
  assign ram_we = (accept && !denied && is_put) ? a_mask : 8'h00;
  assign ram_re = accept && !denied && is_get;

  tl_ram_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .rd_en (ram_re),
    .wr_be (ram_we),
    .addr  (word_idx),
    .wdata (a_data),
    .rdata (ram_rdata)
  );

  // FSM state and latency counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= 4'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next state, handshake outputs and accept strobe
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    a_ready    = 1'b0;
    d_valid    = 1'b0;
    accept     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        a_ready = 1'b1;
        if (a_valid) begin
          accept     = 1'b1;
          cnt_next   = CNT_LOAD;
          state_next = (LATENCY == 1) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_next = cnt_reg - 4'd1;
        if (cnt_reg == 4'd1) begin
          state_next = ST_RESP;
        end
      end
      ST_RESP: begin
        d_valid = 1'b1;
        if (d_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Capture the response fields on accept; held until the next accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_reg <= '0;
    end else if (accept) begin
      req_reg.opcode   <= is_get ? TL_ACCESS_ACK_DATA : TL_ACCESS_ACK;
      req_reg.size     <= a_size;
      req_reg.source   <= a_source;
      req_reg.denied   <= denied;
      req_reg.has_data <= is_get && !denied;
    end
  end

  assign d_opcode = req_reg.opcode;
  assign d_size   = req_reg.size;
  assign d_source = req_reg.source;
  assign d_denied = req_reg.denied;
  assign d_data   = req_reg.has_data ? ram_rdata : 64'd0;

endmodule
